// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    GRANT = 2'b10
  } arb_state_e;

  function automatic int gnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward from start, wrapping at N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = gnt_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;
  int            j;

  always_comb begin
    any   = |req;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      // explicit wrap keeps non-power-of-2 N in range
      j = int'(start) + k;
      if (j >= N) j = j - N;
      cand = IW'(j);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_STATS_EN to add per-producer saturating beat counters on beat_count.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  NUM_REQ   = 4,
  parameter int  WIDTH     = 8,
  parameter int  MAX_BURST = 4,
  localparam int IDW       = gnt_w(NUM_REQ),
  localparam int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr,
  output logic [WIDTH-1:0]         fifo_din,
  output logic                     gnt_valid,
  output logic [IDW-1:0]           gnt_id
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    beat_count
`endif
);

  arb_state_e     state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  beat_cnt;
  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic           sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic           beat;

  rr_pick #(.N(NUM_REQ), .IW(IDW)) u_pick (
    .req   (req_valid),
    .start (rr_ptr),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  // data mux is kept separate so req_data never reaches a control output
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_id == IDW'(i)) sel_data = req_data[i*WIDTH +: WIDTH];
  end

  assign sel_valid = req_valid[gnt_id];

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    fifo_wr   = 1'b0;
    fifo_din  = '0;
    gnt_valid = 1'b0;
    beat      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) state_nxt = GRANT;
      end
      GRANT: begin
        gnt_valid         = 1'b1;
        req_ready[gnt_id] = !fifo_full;
        beat              = sel_valid && !fifo_full;
        fifo_wr           = beat;
        if (beat) fifo_din = sel_data;
        if (!sel_valid || (beat && beat_cnt == CW'(MAX_BURST - 1)))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // nothing leaves the block while reset is held
    if (rst) begin
      req_ready = '0;
      fifo_wr   = 1'b0;
      fifo_din  = '0;
      gnt_valid = 1'b0;
      beat      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_id   <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_any) begin
        gnt_id   <= pick_idx;
        rr_ptr   <= (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + IDW'(1);
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + CW'(1);
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (beat && cnt_q[gnt_id] != 16'hFFFF) begin
      cnt_q[gnt_id] <= cnt_q[gnt_id] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bc
    assign beat_count[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: instance 0 uses MAX_BURST=4, instance 1 uses MAX_BURST=1; a per-cycle reference model checks both.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  vld   [2];
  logic [31:0] dat   [2];
  logic        full  [2];
  logic [3:0]  rdy   [2];
  logic        wr_s  [2];
  logic [7:0]  din_s [2];
  logic        gv_s  [2];
  logic [1:0]  gid_s [2];
`ifdef FIFO_ARB_STATS_EN
  logic [63:0] bc_s  [2];
`endif

  int total = 0;
  int bad   = 0;

  // reference model state: grant held, owner, next scan start, beats taken this grant
  bit busy [2];
  int owner[2];
  int nxt  [2];
  int beats[2];
  int mb   [2];

  // observation logs
  int         wq [2][$];
  int         gq [2][$];
  logic [63:0] wbits[2];
  int         wn [2];
  bit         prev_gv[2];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .MAX_BURST(4)) u_a (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_data(dat[0]), .req_ready(rdy[0]),
    .fifo_full(full[0]), .fifo_wr(wr_s[0]), .fifo_din(din_s[0]), .gnt_valid(gv_s[0]),
    .gnt_id(gid_s[0])
`ifdef FIFO_ARB_STATS_EN
    , .beat_count(bc_s[0])
`endif
  );

  fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .MAX_BURST(1)) u_b (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_data(dat[1]), .req_ready(rdy[1]),
    .fifo_full(full[1]), .fifo_wr(wr_s[1]), .fifo_din(din_s[1]), .gnt_valid(gv_s[1]),
    .gnt_id(gid_s[1])
`ifdef FIFO_ARB_STATS_EN
    , .beat_count(bc_s[1])
`endif
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // compare process: expected outputs from current inputs and model state, then advance the model
  bit         e_wr, e_gv, fnd;
  logic [3:0] e_rdy;
  logic [7:0] e_din;
  int         e_id, pk, q;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      e_wr = 0; e_gv = 0; e_rdy = '0; e_din = '0; e_id = 0;
      if (rst) begin
        busy[k] = 0; nxt[k] = 0; beats[k] = 0; owner[k] = 0;
      end else if (!busy[k]) begin
        fnd = 0; pk = 0;
        for (int s = 0; s < 4; s++) begin
          q = (nxt[k] + s) % 4;
          if (!fnd && vld[k][q]) begin fnd = 1; pk = q; end
        end
        if (fnd) begin
          busy[k] = 1; owner[k] = pk; nxt[k] = (pk + 1) % 4; beats[k] = 0;
        end
      end else begin
        e_gv = 1;
        e_id = owner[k];
        e_rdy[owner[k]] = !full[k];
        e_wr = vld[k][owner[k]] && !full[k];
        if (e_wr) e_din = dat[k][owner[k]*8 +: 8];
        if (!vld[k][owner[k]]) busy[k] = 0;
        else if (e_wr) begin
          beats[k]++;
          if (beats[k] == mb[k]) busy[k] = 0;
        end
      end
      chk($sformatf("fifo_wr[%0d]", k), wr_s[k], e_wr);
      chk($sformatf("req_ready[%0d]", k), rdy[k], e_rdy);
      chk($sformatf("gnt_valid[%0d]", k), gv_s[k], e_gv);
      chk($sformatf("fifo_din[%0d]", k), din_s[k], e_din);
      if (e_gv) chk($sformatf("gnt_id[%0d]", k), gid_s[k], e_id);
      if (wr_s[k]) wq[k].push_back(int'(din_s[k]));
      if (gv_s[k] && !prev_gv[k]) gq[k].push_back(int'(gid_s[k]));
      prev_gv[k] = gv_s[k];
      if (wn[k] < 64) wbits[k][wn[k]] = wr_s[k];
      wn[k]++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 2; k++) begin
      wq[k].delete(); gq[k].delete(); wbits[k] = '0; wn[k] = 0;
    end
  endtask

  // each producer p streams r_p beats of data b_p, b_p+1, ... and drops valid when done;
  // fifo_full is raised for fl cycles once fa beats in total have been accepted
  task automatic run(input int k, input int r0, input int r1, input int r2, input int r3,
                     input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                     input logic [7:0] b3, input int fa, input int fl, input int maxcyc);
    int rem[4]; int sent[4]; logic [7:0] base[4]; bit hs[4];
    int cyc, fleft, tot; bit done;
    rem = '{r0, r1, r2, r3}; base = '{b0, b1, b2, b3};
    for (int p = 0; p < 4; p++) sent[p] = 0;
    cyc = 0; fleft = fl; done = 0;
    while (!done && cyc < maxcyc) begin
      tot = 0;
      for (int p = 0; p < 4; p++) begin
        vld[k][p] = sent[p] < rem[p];
        dat[k][p*8 +: 8] = base[p] + 8'(sent[p]);
        tot += sent[p];
      end
      full[k] = (tot >= fa) && (fleft > 0);
      if (full[k]) fleft--;
      #3;
      for (int p = 0; p < 4; p++) hs[p] = vld[k][p] && rdy[k][p];
      @(posedge clk); #1;
      cyc++;
      done = 1;
      for (int p = 0; p < 4; p++) begin
        if (hs[p]) sent[p]++;
        if (sent[p] < rem[p]) done = 0;
      end
    end
    chk($sformatf("run_complete[%0d]", k), done, 1);
    vld[k] = '0; full[k] = 1'b0;
    step(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mb[0] = 4; mb[1] = 1;
    for (int k = 0; k < 2; k++) begin
      vld[k] = '0; dat[k] = '0; full[k] = 1'b0;
      busy[k] = 0; owner[k] = 0; nxt[k] = 0; beats[k] = 0; prev_gv[k] = 0;
    end
    clear_logs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state and idle inputs
    chk("rst_gnt_id_a", gid_s[0], 0);
    chk("rst_gnt_id_b", gid_s[1], 0);
    chk("rst_gnt_valid_a", gv_s[0], 0);
`ifdef FIFO_ARB_STATS_EN
    chk("rst_stats_a", bc_s[0], 0);
`endif
    clear_logs();
    step(10);
    chk("idle_no_writes", wq[0].size() + wq[1].size(), 0);
    chk("idle_no_grants", gq[0].size() + gq[1].size(), 0);

    // producer 2 alone, 10 beats, bursts of 4/4/2 separated by one bubble
    clear_logs();
    run(0, 0, 0, 10, 0, 8'h00, 8'h00, 8'h20, 8'h00, 0, 0, 60);
    chk("t2_wr_pattern", wbits[0][12:0], 13'b1101111011110);
    chk("t2_nwrites", wq[0].size(), 10);
    for (int i = 0; i < 10 && i < wq[0].size(); i++) chk($sformatf("t2_data%0d", i), wq[0][i], 'h20 + i);
    chk("t2_ngrants", gq[0].size(), 3);
    if (gq[0].size() > 2) chk("t2_grant_last", gq[0][2], 2);

    // all four producers valid, MAX_BURST=1: strict rotation at 50% write duty
    clear_logs();
    run(1, 3, 3, 3, 3, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 0, 0, 80);
    chk("t3_duty", wbits[1][23:0], 24'hAAAAAA);
    chk("t3_ngrants", gq[1].size(), 12);
    for (int i = 0; i < 6 && i < gq[1].size(); i++) chk($sformatf("t3_order%0d", i), gq[1][i], i % 4);
    if (wq[1].size() > 2) chk("t3_third_data", wq[1][2], 'hC0);

    // producer 1 stalled by fifo_full for 5 cycles mid-burst, then finishes the burst
    clear_logs();
    run(0, 0, 4, 0, 0, 8'h00, 8'h10, 8'h00, 8'h00, 2, 5, 60);
    chk("t4_wr_pattern", wbits[0][9:0], 10'b1100000110);
    chk("t4_ngrants", gq[0].size(), 1);
    if (gq[0].size() > 0) chk("t4_grant_id", gq[0][0], 1);
    for (int i = 0; i < 4 && i < wq[0].size(); i++) chk($sformatf("t4_data%0d", i), wq[0][i], 'h10 + i);

    // producer 3 drops valid after 2 beats; producer 0 is served next
    clear_logs();
    run(0, 2, 0, 0, 2, 8'h00, 8'h00, 8'h00, 8'h30, 0, 0, 60);
    chk("t5_wr_pattern", wbits[0][6:0], 7'b1100110);
    chk("t5_ngrants", gq[0].size(), 2);
    if (gq[0].size() > 1) begin
      chk("t5_grant0", gq[0][0], 3);
      chk("t5_grant1", gq[0][1], 0);
    end
    if (wq[0].size() > 2) chk("t5_data2", wq[0][2], 'h00);

    // reset pulse in the middle of a producer-1 burst
    clear_logs();
    dat[0] = 32'h0042_4140;
    vld[0] = 4'b0010;
    step(2);
    chk("t6_pre_rst_wr", wr_s[0], 1);
    chk("t6_pre_rst_id", gid_s[0], 1);
    vld[0] = 4'b0111;
    rst = 1'b1;
    #1;
    chk("t6_async_wr", wr_s[0], 0);
    chk("t6_async_gv", gv_s[0], 0);
`ifdef FIFO_ARB_STATS_EN
    chk("t6_stats_clear", bc_s[0], 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    step(3);
    chk("t6_first_grant_seen", gq[0].size() > 0, 1);
    if (gq[0].size() > 0) chk("t6_first_grant", gq[0][0], 0);
    vld[0] = '0;
    step(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of one FIFO instance (width/depth parameterised) among NUM_REQ independent producers.
- Round-robin arbitration with bounded burst lock: the granted producer owns the write port for up to MAX_BURST beats, then the grant rotates.
- Sits directly in front of the FIFO: drives its wr/din, observes its full flag.

Parameters:
- NUM_REQ, 4, number of producers (2..16).
- WIDTH, 8, data width, must equal the FIFO's width.
- MAX_BURST, 4, max beats per grant (1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  NUM_REQ  per-producer data-valid.
- req_data  input  NUM_REQ*WIDTH  packed data; producer i at [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  per-producer accept; transfer on valid&&ready.
- fifo_full  input  1  FIFO full flag.
- fifo_wr  output  1  FIFO write strobe.
- fifo_din  output  WIDTH  FIFO write data.
- gnt_valid  output  1  a grant is active (state GRANT).
- gnt_id  output  $clog2(NUM_REQ)  index of the granted producer (valid when gnt_valid).

Behaviour:
- Reset: state=IDLE, rr_ptr=0, gnt_id=0, beat_cnt=0. Combinationally, req_ready=0, fifo_wr=0, gnt_valid=0, fifo_din=0. Reset asserted mid-burst aborts the burst immediately; no write issues while rst=1.
- State IDLE: if any req_valid, pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ. Register gnt_id=pick, rr_ptr=(pick+1) mod NUM_REQ, beat_cnt=0, then go to GRANT. If none is valid, stay in IDLE.
- Arbitration latency: exactly 1 cycle; IDLE is always occupied for at least one cycle between grants (one bubble per grant).
- State GRANT:
  - req_ready[gnt_id]=!fifo_full; all other ready bits 0.
  - fifo_wr=req_valid[gnt_id]&&!fifo_full; fifo_din=req_data[gnt_id] (0 when fifo_wr=0).
  - A beat is a cycle with fifo_wr=1; beat_cnt increments on each beat.
  - Leave GRANT to IDLE when either: a beat occurs with beat_cnt==MAX_BURST-1, or req_valid[gnt_id]=0 in this cycle.
  - fifo_full=1 with valid=1: stall, grant held, no beat counted, no timeout.
- Dropped valid: a producer dropping valid ends its grant even if it reasserts next cycle; it then competes again via rr_ptr.
- Outputs and glue: req_ready and fifo_wr are combinational from state, gnt_id, req_valid and fifo_full. No combinational path from req_data to any control output.
- Widths: beat_cnt is $clog2(MAX_BURST+1) bits. rr_ptr wraps from NUM_REQ-1 to 0; for non-power-of-2 NUM_REQ, wrap is explicit compare, not overflow.
- Illegal states: an illegal state encoding returns to IDLE.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined: adds one output per producer, beat_count, NUM_REQ*16 bits, packed like req_data. Each counter increments on every beat of its producer, saturates at 0xFFFF, and clears on rst.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package fifo_arb_pkg: state enum arb_state_e {IDLE, GRANT}; function gnt_w(n)=$clog2(n) as the width helper.
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req vector and start pointer.
  - Outputs: any flag and chosen index.
  - Instantiated once, from IDLE logic.

Test Plan:
- Reset, then req_valid=4'b0000 for 10 cycles -> fifo_wr=0, req_ready=0, gnt_valid=0 throughout.
- Producer 2 alone streams 10 beats (data 0x20..0x29), MAX_BURST=4, fifo_full=0.
  - Writes occur in bursts of 4, 4, 2, with one IDLE bubble between bursts.
  - FIFO receives 0x20..0x29 in order.
- All four producers valid continuously, MAX_BURST=1, after reset -> grant order is 0,1,2,3,0,1; fifo_wr duty is 50%.
- Producer 1 granted, fifo_full=1 for 5 cycles mid-burst.
  - req_ready[1]=0 and fifo_wr=0 for those cycles; gnt_id stays 1.
  - After full deasserts, the burst completes the remaining beats.
- Producer 3 drops valid after 2 of 4 beats while producer 0 is valid -> GRANT exits, next grant goes to 0 (rr_ptr=0). Producer 3 gets no ready while invalid.
- rst pulsed for 1 cycle in the middle of a producer-1 burst.
  - fifo_wr drops to 0 asynchronously.
  - After release, the first grant goes to the lowest-index valid producer.
  - With FIFO_ARB_STATS_EN, counters read 0.
